// File: rtl/aes_word_packer.sv
// aes_word_packer: assembles four 32-bit bus beats into 129-bit words.
// Bit 128 of each word is the mode flag and bits 127:0 are the payload.
// Completed words are buffered in a small FIFO. Each word is presented on
// data_in together with a one-cycle read strobe.
//
// Ports:
//   clk, rst            clock (rising edge), asynchronous active-high reset
//   wr_en, wr_data      beat valid and beat payload (most-significant beat first)
//   wr_first            beat 0 marker; resyncs a partially assembled word
//   wr_mode             mode flag, sampled on beat 0 only
//   wr_par              per-byte even parity, checked only with PACK_PARITY_EN
//   wr_ready            beat accepted this cycle if wr_en
//   pack_hold           downstream stall, blocks pops
//   read, data_in       one-cycle strobe and registered head word
//   overflow            sticky, set when a beat is offered while wr_ready=0
//   frag_err            pulse, set when a partial word is discarded on resync
//   par_err             pulse, set when a word is dropped on parity (0 if disabled)
//   err_clr             synchronous clear of overflow
//
// Optional feature macro: PACK_PARITY_EN (per-byte parity check on beats).
module aes_word_packer #(
  parameter int unsigned BEAT_W     = 32,
  parameter int unsigned FIFO_DEPTH = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              wr_en,
  input  logic [BEAT_W-1:0] wr_data,
  input  logic              wr_first,
  input  logic              wr_mode,
  input  logic [3:0]        wr_par,
  output logic              wr_ready,
  input  logic              pack_hold,
  output logic              read,
  output logic [4*BEAT_W:0] data_in,
  output logic              overflow,
  output logic              frag_err,
  output logic              par_err,
  input  logic              err_clr
);

  localparam int unsigned AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int unsigned WW = 4 * BEAT_W + 1;
  localparam bit [AW:0] FullCount = FIFO_DEPTH[AW:0];

  typedef enum logic [0:0] {StIdle, StFill} state_e;

  state_e               state_q, state_d;
  logic [1:0]           cnt_q, cnt_d;
  logic [4*BEAT_W-1:0]  asm_q, asm_d;
  logic                 mode_q, mode_d;
  logic                 bad_q, bad_d;
  logic                 frag_q, frag_d;
  logic                 par_q, par_d;
  logic                 ovf_q, ovf_d;
  logic                 ready_en_q;
  logic                 push, pop, accept, beat_bad;
  logic [WW-1:0]        push_word;

  logic [WW-1:0]        mem_q [FIFO_DEPTH];
  logic [AW-1:0]        wr_ptr_q, rd_ptr_q;
  logic [AW:0]          count_q;
  logic                 fifo_full, fifo_empty;
  logic                 read_q;
  logic [WW-1:0]        data_q;

`ifdef PACK_PARITY_EN
  always_comb begin
    beat_bad = 1'b0;
    for (int i = 0; i < 4; i++) begin
      if ((^wr_data[8*i +: 8]) != wr_par[i]) beat_bad = 1'b1;
    end
  end
`else
  logic unused_wr_par;
  assign unused_wr_par = ^wr_par;
  assign beat_bad      = 1'b0;
`endif

  assign fifo_full  = (count_q == FullCount);
  assign fifo_empty = (count_q == '0);
  // Held low until the first clock after reset releases.
  assign wr_ready   = ready_en_q && !fifo_full;
  assign accept     = wr_en && wr_ready;
  assign pop        = !fifo_empty && !pack_hold;
  assign push_word  = {mode_q, asm_q[4*BEAT_W-1:BEAT_W], wr_data};

  // Assembly FSM next state.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    asm_d   = asm_q;
    mode_d  = mode_q;
    bad_d   = bad_q;
    frag_d  = 1'b0;
    par_d   = 1'b0;
    push    = 1'b0;
    if (accept) begin
      if (state_q == StIdle || wr_first) begin
        frag_d  = (state_q == StFill);
        asm_d   = {wr_data, {(3*BEAT_W){1'b0}}};
        mode_d  = wr_mode;
        bad_d   = beat_bad;
        cnt_d   = 2'd1;
        state_d = StFill;
      end else begin
        case (cnt_q)
          2'd1:    asm_d[3*BEAT_W-1 -: BEAT_W] = wr_data;
          2'd2:    asm_d[2*BEAT_W-1 -: BEAT_W] = wr_data;
          default: begin
            asm_d[BEAT_W-1:0] = wr_data;
            state_d           = StIdle;
            bad_d             = 1'b0;
            if (bad_q || beat_bad) par_d = 1'b1;
            else                   push  = 1'b1;
          end
        endcase
        cnt_d = (cnt_q == 2'd3) ? 2'd0 : cnt_q + 2'd1;
      end
    end
  end

  // Set wins over clear.
  always_comb begin
    ovf_d = ovf_q;
    if (wr_en && !wr_ready) ovf_d = 1'b1;
    else if (err_clr)       ovf_d = 1'b0;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= StIdle;
      cnt_q      <= '0;
      asm_q      <= '0;
      mode_q     <= 1'b0;
      bad_q      <= 1'b0;
      frag_q     <= 1'b0;
      par_q      <= 1'b0;
      ovf_q      <= 1'b0;
      ready_en_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      asm_q      <= asm_d;
      mode_q     <= mode_d;
      bad_q      <= bad_d;
      frag_q     <= frag_d;
      par_q      <= par_d;
      ovf_q      <= ovf_d;
      ready_en_q <= 1'b1;
    end
  end

  // Word FIFO and registered output stage.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < FIFO_DEPTH; i++) mem_q[i] <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      read_q   <= 1'b0;
      data_q   <= '0;
    end else begin
      if (push) begin
        mem_q[wr_ptr_q] <= push_word;
        wr_ptr_q        <= wr_ptr_q + 1'b1;
      end
      if (pop) begin
        data_q   <= mem_q[rd_ptr_q];
        rd_ptr_q <= rd_ptr_q + 1'b1;
      end
      read_q <= pop;
      case ({push, pop})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
    end
  end

  assign read     = read_q;
  assign data_in  = data_q;
  assign overflow = ovf_q;
  assign frag_err = frag_q;
  // Never set when parity checking is compiled out.
  assign par_err  = par_q;

endmodule
